ssd_scan_ctrl: RTL and testbench
================================

// Module: ssd_scan_ctrl
// PURPOSE
//   Parametrised multi-digit seven-segment display controller for the datapath top level.
//   Takes a binary value from the datapath, such as a register or PC selected for the board display.
//   Converts it to BCD with a sequential double-dabble engine.
//   Time-multiplexes the digits onto shared segment lines, with optional leading-zero blanking
//   and overflow indication.
// PARAMETERS
//   DIGITS      4       number of display digits / anode lines (>=1)
//   VAL_W       16      width of binary input value (>=1)
//   DIV         100000  clk cycles each digit stays lit (>=1; 1 = advance every cycle)
//   ACTIVE_LOW  1       1: anodes and segments active-low; 0: active-high
// PORTS
//   clk       in   1       system clock; everything rising-edge
//   rst       in   1       synchronous reset, active-high
//   value     in   VAL_W   unsigned binary value to display
//   load      in   1       1-cycle strobe: capture value and start conversion
//   blank_lz  in   1       1: blank leading zero digits
//   busy      out  1       conversion in progress
//   ovf       out  1       last converted value exceeded DIGITS decimal digits
//   anodes    out  DIGITS  one-hot digit enable (polarity per ACTIVE_LOW)
//   seg       out  7       segments {g,f,e,d,c,b,a}, seg[0]=a (polarity per ACTIVE_LOW)
// BEHAVIOUR
// - Reset values: busy=0, ovf=0, display register=0, scan index=0, prescaler=0.
//   anodes are all off and seg is all off during the reset cycle.
//   Digit 0 is lit from the first cycle after rst deasserts.
// - FSM states: IDLE, CONV, UPDATE.
//   IDLE -> CONV when load=1. value is captured into a shift register; the BCD scratch is cleared.
//   CONV runs exactly VAL_W cycles. Each cycle: add 3 to every scratch nibble >=5, then shift
//   {scratch,shreg} left by 1.
//   CONV -> UPDATE when the VAL_W-th shift completes.
//   UPDATE -> IDLE after 1 cycle. UPDATE copies the low DIGITS nibbles to the display register
//   and sets ovf.
// - Scratch holds NDEC = VAL_W*302/1000+1 nibbles.
//   ovf=1 iff any nibble at index >= DIGITS is nonzero.
//   ovf holds until the next UPDATE.
// - busy=1 in CONV and UPDATE.
//   load at edge N: busy=1 from N+1; display register and ovf are valid and busy=0 at N+VAL_W+2.
// - load is ignored (dropped, not queued) while busy=1.
//   The display keeps showing the old value during a conversion.
// - Scan:
//   - Prescaler counts 0..DIV-1.
//   - On the wrap from DIV-1 to 0, the scan index advances, wrapping DIGITS-1 -> 0.
//   - anodes enables only the digit at the scan index.
// - Segment decode:
//   - Digits 0-9 use standard patterns.
//   - With ovf=1, every digit shows '-' (g only) and blanking is ignored.
//   - Nibbles >9 cannot occur; if they do, the digit shows all segments off.
// - Leading-zero blanking: with blank_lz=1 and ovf=0, digit i>0 is blanked (segments off, anode
//   still driven) if it and all more significant digits are 0. Digit 0 is never blanked.
// - anodes and seg are registered. Each cycle they reflect the scan index, display register and
//   blank_lz as sampled at the previous edge.
// - rst while CONV or UPDATE aborts the conversion: busy=0, display register=0 and ovf=0 on the
//   next cycle.
// TESTING (DIGITS=4, VAL_W=16, DIV=4, ACTIVE_LOW=1)
// 1. rst; load value=1234 -> busy=1 for 17 cycles, ovf=0.
//    Digits 3..0 then show 1,2,3,4; digit 0 has anodes=4'b1110, seg=7'b0011001.
// 2. load value=12345 -> ovf=1, every digit shows seg=7'b0111111; a later load of 42 clears ovf.
// 3. blank_lz=1, value=7 -> digits 3..1 show seg=7'h7F; digit 0 shows 7'b1111000.
//    value=0 -> digit 0 shows 7'b1000000.
// 4. load 1234, then load 9999 on busy cycle 5 -> 9999 is dropped, the display shows 1234,
//    busy falls at N+18.
// 5. rst pulse on CONV cycle 8 -> next cycle busy=0, ovf=0, all segments off.
//    Afterwards digit 0 shows 0 with anodes=4'b1110.
// 6. DIV=1 -> anodes sequence 1110,1101,1011,0111,1110 on consecutive cycles (wrap check).

Source files
------------

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - multi-digit seven-segment scan controller with double-dabble BCD
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   value, load       binary value and 1-cycle strobe that starts a conversion
//   blank_lz          blank leading zero digits (digit 0 never blanked)
//   busy              conversion in progress (CONV or UPDATE)
//   ovf               last converted value needs more than DIGITS decimal digits
//   anodes            one-hot digit enable
//   seg               segments {g,f,e,d,c,b,a}
module ssd_scan_ctrl #(
    parameter int DIGITS     = 4,
    parameter int VAL_W      = 16,
    parameter int DIV        = 100000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VAL_W-1:0]  value,
    input  logic              load,
    input  logic              blank_lz,
    output logic              busy,
    output logic              ovf,
    output logic [DIGITS-1:0] anodes,
    output logic [6:0]        seg
);
    localparam int NDEC = VAL_W * 302 / 1000 + 1;
    // Scratch is widened to at least DIGITS nibbles so the display copy never
    // reads past it; extra nibbles stay zero and never trigger the +3 step.
    localparam int NS   = (NDEC > DIGITS) ? NDEC : DIGITS;
    localparam int SW   = NS * 4;
    localparam int CW   = (VAL_W > 1) ? $clog2(VAL_W) : 1;
    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t              state;
    logic [VAL_W-1:0]    shreg;
    logic [SW-1:0]       scratch;
    logic [CW-1:0]       bit_cnt;
    logic [3:0]          disp [DIGITS];
    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;

    logic [SW-1:0]       adj;
    logic [SW+VAL_W-1:0] shifted;
    logic                ovf_next;
    logic [DIGITS-1:0]   lz;
    logic                lz_run;
    logic [3:0]          cur;
    logic [6:0]          pat;
    logic [6:0]          seg_on;
    logic [DIGITS-1:0]   an_on;

    // Double-dabble step: correct nibbles >= 5, then shift {scratch, shreg} left.
    always_comb begin
        adj = scratch;
        for (int k = 0; k < NS; k++) begin
            if (scratch[k*4 +: 4] >= 4'd5)
                adj[k*4 +: 4] = scratch[k*4 +: 4] + 4'd3;
        end
        shifted = {adj, shreg} << 1;
        ovf_next = 1'b0;
        for (int k = DIGITS; k < NS; k++)
            ovf_next = ovf_next | (|scratch[k*4 +: 4]);
    end

    // lz[i] is set when digit i and every more significant digit are zero.
    always_comb begin
        lz_run = 1'b1;
        lz     = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lz_run = lz_run & (disp[i] == 4'd0);
            lz[i]  = lz_run;
        end
    end

    always_comb begin
        cur = disp[idx];
        case (cur)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h00;
        endcase
        if (ovf)
            seg_on = 7'h40;
        else if (blank_lz && lz[idx])
            seg_on = 7'h00;
        else
            seg_on = pat;
        an_on      = '0;
        an_on[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            ovf     <= 1'b0;
            shreg   <= '0;
            scratch <= '0;
            bit_cnt <= '0;
            for (int i = 0; i < DIGITS; i++)
                disp[i] <= 4'd0;
            presc   <= '0;
            idx     <= '0;
            anodes  <= {DIGITS{ACTIVE_LOW}};
            seg     <= {7{ACTIVE_LOW}};
        end else begin
            anodes <= ACTIVE_LOW ? ~an_on : an_on;
            seg    <= ACTIVE_LOW ? ~seg_on : seg_on;

            if (presc == PW'(DIV - 1)) begin
                presc <= '0;
                idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (load) begin
                        shreg   <= value;
                        scratch <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    scratch <= shifted[SW+VAL_W-1:VAL_W];
                    shreg   <= shifted[VAL_W-1:0];
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CW'(VAL_W - 1))
                        state <= UPDATE;
                end
                UPDATE: begin
                    for (int i = 0; i < DIGITS; i++)
                        disp[i] <= scratch[i*4 +: 4];
                    ovf   <= ovf_next;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb/tb_ssd_scan_ctrl.sv - directed self-checking bench for ssd_scan_ctrl
module tb_ssd_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        blank_lz;
    logic [15:0] value;
    logic        busy, ovf, busy1, ovf1;
    logic [3:0]  anodes, anodes1;
    logic [6:0]  seg, seg1;

    int          passed = 0;
    int          total  = 0;
    logic [6:0]  got [4];
    logic        bad_an;

    always #5 clk = ~clk;

    ssd_scan_ctrl #(.DIGITS(4), .VAL_W(16), .DIV(4), .ACTIVE_LOW(1'b1)) u_dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz),
        .busy(busy), .ovf(ovf), .anodes(anodes), .seg(seg)
    );

    ssd_scan_ctrl #(.DIGITS(4), .VAL_W(16), .DIV(1), .ACTIVE_LOW(1'b1)) u_fast (
        .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz),
        .busy(busy1), .ovf(ovf1), .anodes(anodes1), .seg(seg1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        tick;
        load  = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick;
        end
    endtask

    task automatic scan_all;
        bad_an = 1'b0;
        for (int i = 0; i < 4; i++) got[i] = 7'bx;
        for (int c = 0; c < 20; c++) begin
            case (anodes)
                4'b1110: got[0] = seg;
                4'b1101: got[1] = seg;
                4'b1011: got[2] = seg;
                4'b0111: got[3] = seg;
                default: bad_an = 1'b1;
            endcase
            tick;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0;
        tick;
        tick;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else passed++;
        total++; if (anodes !== 4'hF) $display("FAIL reset_anodes got %b want 1111", anodes); else passed++;
        total++; if (seg !== 7'h7F) $display("FAIL reset_seg got %b want 1111111", seg); else passed++;
        rst = 1'b0;
        tick;
        total++; if (anodes !== 4'b1110) $display("FAIL first_anodes got %b want 1110", anodes); else passed++;
        total++; if (seg !== 7'h40) $display("FAIL first_seg got %b want 1000000", seg); else passed++;
    endtask

    task automatic test_convert;
        int n;
        logic [6:0] want [4];
        do_load(16'd1234);
        wait_idle(n);
        total++; if (n != 17) $display("FAIL conv_busy_cycles got %0d want 17", n); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL conv_ovf got %b want 0", ovf); else passed++;
        tick;
        scan_all;
        want = '{7'h19, 7'h30, 7'h24, 7'h79};
        for (int i = 0; i < 4; i++) begin
            total++; if (got[i] !== want[i]) $display("FAIL conv_1234_d%0d got %b want %b", i, got[i], want[i]); else passed++;
        end
        total++; if (bad_an !== 1'b0) $display("FAIL conv_anode_onehot got %b want 0", bad_an); else passed++;
    endtask

    task automatic test_overflow;
        int n;
        logic [6:0] want [4];
        do_load(16'd12345);
        wait_idle(n);
        total++; if (ovf !== 1'b1) $display("FAIL ovf_set got %b want 1", ovf); else passed++;
        tick;
        scan_all;
        for (int i = 0; i < 4; i++) begin
            total++; if (got[i] !== 7'h3F) $display("FAIL ovf_dash_d%0d got %b want 0111111", i, got[i]); else passed++;
        end
        do_load(16'd42);
        wait_idle(n);
        total++; if (ovf !== 1'b0) $display("FAIL ovf_clear got %b want 0", ovf); else passed++;
        tick;
        scan_all;
        want = '{7'h24, 7'h19, 7'h40, 7'h40};
        for (int i = 0; i < 4; i++) begin
            total++; if (got[i] !== want[i]) $display("FAIL val42_d%0d got %b want %b", i, got[i], want[i]); else passed++;
        end
    endtask

    task automatic test_blanking;
        int n;
        logic [6:0] want [4];
        blank_lz = 1'b1;
        do_load(16'd7);
        wait_idle(n);
        tick;
        scan_all;
        want = '{7'h78, 7'h7F, 7'h7F, 7'h7F};
        for (int i = 0; i < 4; i++) begin
            total++; if (got[i] !== want[i]) $display("FAIL blank7_d%0d got %b want %b", i, got[i], want[i]); else passed++;
        end
        do_load(16'd0);
        wait_idle(n);
        tick;
        scan_all;
        want = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        for (int i = 0; i < 4; i++) begin
            total++; if (got[i] !== want[i]) $display("FAIL blank0_d%0d got %b want %b", i, got[i], want[i]); else passed++;
        end
        do_load(16'd105);
        wait_idle(n);
        tick;
        scan_all;
        want = '{7'h12, 7'h40, 7'h79, 7'h7F};
        for (int i = 0; i < 4; i++) begin
            total++; if (got[i] !== want[i]) $display("FAIL blank105_d%0d got %b want %b", i, got[i], want[i]); else passed++;
        end
        do_load(16'd65535);
        wait_idle(n);
        tick;
        scan_all;
        for (int i = 0; i < 4; i++) begin
            total++; if (got[i] !== 7'h3F) $display("FAIL blank_ovf_d%0d got %b want 0111111", i, got[i]); else passed++;
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_back_to_back;
        int n;
        logic [6:0] want [4];
        do_load(16'd1234);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy === 1'b1) n++;
            tick;
        end
        value = 16'd9999;
        load  = 1'b1;
        if (busy === 1'b1) n++;
        tick;
        load  = 1'b0;
        value = '0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick;
        end
        total++; if (n != 17) $display("FAIL b2b_busy_cycles got %0d want 17", n); else passed++;
        tick;
        tick;
        total++; if (busy !== 1'b0) $display("FAIL b2b_no_requeue got %b want 0", busy); else passed++;
        scan_all;
        want = '{7'h19, 7'h30, 7'h24, 7'h79};
        for (int i = 0; i < 4; i++) begin
            total++; if (got[i] !== want[i]) $display("FAIL b2b_d%0d got %b want %b", i, got[i], want[i]); else passed++;
        end
    endtask

    task automatic test_abort;
        int n;
        do_load(16'd12345);
        wait_idle(n);
        do_load(16'd1234);
        repeat (7) tick;
        rst = 1'b1;
        tick;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL abort_ovf got %b want 0", ovf); else passed++;
        total++; if (seg !== 7'h7F) $display("FAIL abort_seg got %b want 1111111", seg); else passed++;
        total++; if (anodes !== 4'hF) $display("FAIL abort_anodes got %b want 1111", anodes); else passed++;
        rst = 1'b0;
        tick;
        total++; if (anodes !== 4'b1110) $display("FAIL abort_d0_anodes got %b want 1110", anodes); else passed++;
        total++; if (seg !== 7'h40) $display("FAIL abort_d0_seg got %b want 1000000", seg); else passed++;
        tick;
        scan_all;
        for (int i = 0; i < 4; i++) begin
            total++; if (got[i] !== 7'h40) $display("FAIL abort_zero_d%0d got %b want 1000000", i, got[i]); else passed++;
        end
    endtask

    task automatic test_fast_scan;
        logic [3:0] want [5];
        want = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            total++; if (anodes1 !== want[i]) $display("FAIL div1_anodes_%0d got %b want %b", i, anodes1, want[i]); else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_convert;
        test_overflow;
        test_blanking;
        test_back_to_back;
        test_abort;
        test_fast_scan;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
